uart_tx_stage: RTL and testbench
================================

// Module: uart_tx_stage
// PURPOSE
//   Serialises 8-bit values from the upstream 8-bit counter stage onto a single UART line (8N1, LSB first).
//   It sits directly downstream of that counter and takes bytes over a valid/ready handshake.
//   A one-entry holding register buffers the next byte while the current frame shifts out.
//   This allows back-to-back frames with no idle gap.
// PARAMETERS
//   CLKS_PER_BIT  16  enabled clk cycles per UART bit; legal range 2..65535
// PORTS
//   clk       in   1  clock; all state updates on rising edge
//   rst       in   1  asynchronous, active-high reset
//   ena       in   1  bit-timing enable; low freezes baud counter and FSM
//   in_data   in   8  byte to transmit (from counter output)
//   in_valid  in   1  in_data valid
//   in_ready  out  1  holding register empty; byte accepted when in_valid & in_ready at clk edge
//   tx        out  1  serial line, registered, idle high
//   busy      out  1  high while the FSM is not in IDLE or the holding register is full
// BEHAVIOUR
//   Reset (async, rst=1): tx=1, in_ready=1, busy=0, state=IDLE, holding register cleared.
//     Baud and bit counters are zeroed. A frame in flight is abandoned and its byte is lost.
//   Handshake:
//     - in_ready = !hold_full, driven from a register with no combinational path from in_valid.
//     - Accept edge: hold <= in_data, hold_full <= 1.
//     - Acceptance does not depend on ena.
//     - in_valid while hold_full: stall; the upstream holds in_data stable.
//   FSM states: IDLE, START, DATA, STOP.
//     - IDLE: tx=1. On an edge with ena=1 and hold_full=1:
//       shift <= hold, hold_full <= 0, tx <= 0, baud <= 0, state <= START.
//     - START: tx=0 for CLKS_PER_BIT enabled cycles, then tx <= shift[0], bit <= 0, state <= DATA.
//     - DATA: each bit lasts CLKS_PER_BIT enabled cycles, LSB first.
//       At the end of bit n<7: shift >>= 1, tx <= next bit. At the end of bit 7: tx <= 1, state <= STOP.
//     - STOP: tx=1 for CLKS_PER_BIT enabled cycles. At the end of the stop bit:
//       if hold_full, load directly as from IDLE (next START begins, no gap); else state <= IDLE.
//   Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
//     Its width is clog2(CLKS_PER_BIT). It increments only when ena=1.
//   ena=0: baud counter, bit counter, shift register, state and tx are all held.
//     The current bit is stretched by the number of disabled cycles.
//   Latency: byte accepted at edge E0 from idle with empty hold -> tx falls at E1 (given ena=1).
//     The full frame is 10*CLKS_PER_BIT enabled cycles.
//   Simultaneous load and accept: in_ready is low on the loading edge, so a new byte lands one edge later.
//     A byte can still arrive during START, well before STOP ends, so the back-to-back path is unaffected.
//   busy = (state != IDLE) | hold_full, registered-equivalent (decoded from registers only).
// TESTING
//   T1 reset: hold rst=1 with random inputs -> tx=1, in_ready=1, busy=0.
//      Release rst: all three hold and tx stays 1.
//   T2 single byte, CLKS_PER_BIT=4, ena=1: send 0xA5 ->
//      from E1, tx = 0,1,0,1,0,0,1,0,1,1 with each level lasting 4 cycles (40 total).
//      busy falls after the stop bit.
//   T3 back-to-back: 0x00 then 0xFF with in_valid held ->
//      second byte accepted one edge after the first load.
//      The stop bit of 0x00 is followed immediately by the start bit of 0xFF, with 0 idle cycles.
//   T4 ena gating: 0x3C with ena=0 for 7 cycles during data bit 3 ->
//      bit 3 lasts 4+7 cycles, all other bits last 4 cycles, and the decoded byte is 0x3C.
//   T5 stall: hold full and in_valid=1 with in_data changing ->
//      no acceptance while in_ready=0.
//      The byte transmitted is the value present on the edge where in_ready=1.
//   T6 reset mid-frame: assert rst during data bit 5 of 0xC3 ->
//      tx=1 asynchronously, before the next clk edge, and in_ready=1.
//      A subsequent 0x81 is transmitted with correct framing.

Source files
------------

// File: rtl/uart_tx_stage.sv
// 8N1 UART transmitter, LSB first, fed over a valid/ready handshake.
// A one-entry holding register lets the next byte load at the end of the stop bit.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line high, waiting for an enabled cycle with the holding reg full
// START | start bit (tx low) for CLKS_PER_BIT enabled cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT enabled cycles each
// STOP  | stop bit (tx high); reloads straight into START if a byte waits
module uart_tx_stage #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       busy
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [BAUD_W-1:0] baud;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift;
   logic [7:0]        hold;
   logic              hold_full;

   logic              bit_end;
   logic              last_bit;
   logic              load;
   logic              accept;

   logic              tx_nxt;
   logic              shift_adv;
   logic              bit_clr;
   logic              bit_inc;

   assign bit_end  = ena && (state != S_IDLE) && (baud == BAUD_LAST);
   assign last_bit = (bit_cnt == 3'd7);
   // Loading empties the holding register, so in_ready is still low on that edge
   assign load     = ena && hold_full &&
                     ((state == S_IDLE) || ((state == S_STOP) && bit_end));
   assign accept   = in_valid && !hold_full;

   assign in_ready = !hold_full;
   assign busy     = (state != S_IDLE) || hold_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (load) begin
               state_nxt = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end && last_bit) begin
               state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (load) begin
               state_nxt = S_START;
            end else if (bit_end) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      tx_nxt    = tx;
      shift_adv = 1'b0;
      bit_clr   = 1'b0;
      bit_inc   = 1'b0;
      case (state)
         S_IDLE: begin
            tx_nxt = load ? 1'b0 : 1'b1;
         end
         S_START: begin
            if (bit_end) begin
               tx_nxt  = shift[0];
               bit_clr = 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (last_bit) begin
                  tx_nxt = 1'b1;
               end else begin
                  tx_nxt    = shift[1];
                  shift_adv = 1'b1;
                  bit_inc   = 1'b1;
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               tx_nxt = load ? 1'b0 : 1'b1;
            end
         end
         default: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx <= 1'b1;
      end else begin
         tx <= tx_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud <= '0;
      end else if (load) begin
         baud <= '0;
      end else if (ena && (state != S_IDLE)) begin
         baud <= bit_end ? '0 : baud + BAUD_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= 3'd0;
      end else if (bit_clr) begin
         bit_cnt <= 3'd0;
      end else if (bit_inc) begin
         bit_cnt <= bit_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift <= 8'h00;
      end else if (load) begin
         shift <= hold;
      end else if (shift_adv) begin
         shift <= {1'b0, shift[7:1]};
      end
   end

   // Acceptance ignores ena; load and accept never coincide since one needs
   // hold_full set and the other clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold      <= 8'h00;
         hold_full <= 1'b0;
      end else if (accept) begin
         hold      <= in_data;
         hold_full <= 1'b1;
      end else if (load) begin
         hold_full <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_stage.sv
// Bench for uart_tx_stage: scenario tasks with inline checks, plus a queue-based
// line model that predicts tx, busy and in_ready every cycle.
module tb_uart_tx_stage;

   localparam int N = 4;
   localparam int FRAME = 10 * N;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       tx;
   logic       busy;

   int checks = 0;
   int errors = 0;

   uart_tx_stage #(.CLKS_PER_BIT(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx       (tx),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic frame_level(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return b[k-1];
   endfunction

   // Line model: one queued level per enabled cycle of the frame being sent,
   // plus a one-deep queue of accepted bytes.
   logic       c_ena = 1'b0;
   logic       c_valid = 1'b0;
   logic       c_rst = 1'b1;
   logic [7:0] c_data = 8'h00;
   logic       lv[$];
   logic [7:0] pend[$];
   logic       m_acc;
   logic [7:0] m_b;
   logic       m_tx;
   logic       m_busy;
   logic       m_rdy;

   always @(negedge clk) begin
      c_ena   = ena;
      c_valid = in_valid;
      c_data  = in_data;
      c_rst   = rst;
   end

   always @(posedge clk) begin
      #1;
      if (rst || c_rst) begin
         lv.delete();
         pend.delete();
      end else begin
         m_acc = c_valid && (pend.size() == 0);
         if (c_ena) begin
            if (lv.size() > 0) void'(lv.pop_front());
            if (lv.size() == 0 && pend.size() > 0) begin
               m_b = pend.pop_front();
               for (int k = 0; k < 10; k++)
                  for (int c = 0; c < N; c++) lv.push_back(frame_level(m_b, k));
            end
         end
         if (m_acc) pend.push_back(c_data);
      end
      m_tx   = (lv.size() > 0) ? lv[0] : 1'b1;
      m_busy = (lv.size() > 0) || (pend.size() > 0);
      m_rdy  = (pend.size() == 0);
      checks++;
      if (tx !== m_tx || busy !== m_busy || in_ready !== m_rdy) begin
         errors++;
         $display("FAIL model t=%0t tx/busy/rdy got %b%b%b expected %b%b%b",
                  $time, tx, busy, in_ready, m_tx, m_busy, m_rdy);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ena      = 1'($urandom_range(0, 1));
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 8'($urandom_range(0, 255));
         tick();
         checks++;
         if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_held tx/rdy/busy got %b%b%b expected 110", tx, in_ready, busy);
         end
      end
      in_valid = 1'b0;
      ena      = 1'b1;
      rst      = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release tx/rdy/busy got %b%b%b expected 110", tx, in_ready, busy);
         end
      end
   endtask

   task automatic test_single();
      logic s[0:FRAME-1];
      logic bz[0:FRAME-1];
      ena      = 1'b1;
      in_data  = 8'hA5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || tx !== 1'b1) begin
         errors++;
         $display("FAIL single_accept rdy/busy/tx got %b%b%b expected 011", in_ready, busy, tx);
      end
      for (int j = 0; j < FRAME; j++) begin
         tick();
         s[j]  = tx;
         bz[j] = busy;
      end
      for (int j = 0; j < FRAME; j++) begin
         checks++;
         if (s[j] !== frame_level(8'hA5, j / N) || bz[j] !== 1'b1) begin
            errors++;
            $display("FAIL single_wave cycle %0d tx/busy got %b%b expected %b1",
                     j, s[j], bz[j], frame_level(8'hA5, j / N));
         end
      end
      tick();
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL single_end busy/tx got %b%b expected 01", busy, tx);
      end
   endtask

   task automatic test_back_to_back();
      logic s[0:2*FRAME];
      logic exp;
      ena      = 1'b1;
      in_data  = 8'h00;
      in_valid = 1'b1;
      tick();
      in_data  = 8'hFF;
      tick();
      s[0] = tx;
      checks++;
      if (in_ready !== 1'b1 || tx !== 1'b0) begin
         errors++;
         $display("FAIL b2b_load rdy/tx got %b%b expected 10", in_ready, tx);
      end
      tick();
      s[1] = tx;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second_accept rdy got %b expected 0", in_ready);
      end
      for (int j = 2; j <= 2 * FRAME; j++) begin
         tick();
         s[j] = tx;
      end
      for (int j = 0; j < 2 * FRAME; j++) begin
         exp = (j < FRAME) ? frame_level(8'h00, j / N) : frame_level(8'hFF, (j - FRAME) / N);
         checks++;
         if (s[j] !== exp) begin
            errors++;
            $display("FAIL b2b_wave cycle %0d tx got %b expected %b", j, s[j], exp);
         end
      end
      checks++;
      if (s[FRAME-1] !== 1'b1 || s[FRAME] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap stop/start got %b%b expected 10", s[FRAME-1], s[FRAME]);
      end
      checks++;
      if (s[2*FRAME] !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end tx/busy got %b%b expected 10", s[2*FRAME], busy);
      end
   endtask

   task automatic test_ena_gating();
      localparam int OFF_AT = 17;
      localparam int OFF_LEN = 7;
      logic s[0:FRAME+OFF_LEN];
      logic bz[0:FRAME+OFF_LEN];
      logic [7:0] dec;
      int e;
      int bit3_len;
      ena      = 1'b1;
      in_data  = 8'h3C;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int j = 0; j <= FRAME + OFF_LEN; j++) begin
         tick();
         s[j]  = tx;
         bz[j] = busy;
         ena   = (j >= OFF_AT && j < OFF_AT + OFF_LEN) ? 1'b0 : 1'b1;
      end
      ena = 1'b1;
      bit3_len = 0;
      for (int j = 0; j < FRAME + OFF_LEN; j++) begin
         e = (j <= OFF_AT) ? j : ((j <= OFF_AT + OFF_LEN) ? OFF_AT : j - OFF_LEN);
         if (e / N == 4) bit3_len++;
         checks++;
         if (s[j] !== frame_level(8'h3C, e / N) || bz[j] !== 1'b1) begin
            errors++;
            $display("FAIL gate_wave cycle %0d tx/busy got %b%b expected %b1",
                     j, s[j], bz[j], frame_level(8'h3C, e / N));
         end
      end
      checks++;
      if (bit3_len != N + OFF_LEN) begin
         errors++;
         $display("FAIL gate_bit3_len got %0d expected %0d", bit3_len, N + OFF_LEN);
      end
      for (int n = 0; n < 8; n++) begin
         e = (n + 1) * N + N / 2;
         dec[n] = s[(e <= OFF_AT) ? e : e + OFF_LEN];
      end
      checks++;
      if (dec !== 8'h3C) begin
         errors++;
         $display("FAIL gate_decode got %h expected 3c", dec);
      end
      checks++;
      if (s[FRAME+OFF_LEN] !== 1'b1 || bz[FRAME+OFF_LEN] !== 1'b0) begin
         errors++;
         $display("FAIL gate_end tx/busy got %b%b expected 10", s[FRAME+OFF_LEN], bz[FRAME+OFF_LEN]);
      end
   endtask

   task automatic test_stall();
      logic s[0:FRAME-1];
      logic [7:0] final_b;
      logic [7:0] dec;
      int edge_n;
      ena      = 1'b1;
      in_data  = 8'h11;
      in_valid = 1'b1;
      tick();
      in_data = 8'h22;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_after_load rdy got %b expected 1", in_ready);
      end
      tick();
      edge_n = 2;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_full rdy got %b expected 0", in_ready);
      end
      while (edge_n < FRAME + 1) begin
         in_data = 8'($urandom_range(0, 255));
         tick();
         edge_n++;
         checks++;
         if (in_ready !== ((edge_n >= FRAME + 1) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL stall_ready edge %0d rdy got %b expected %b",
                     edge_n, in_ready, (edge_n >= FRAME + 1));
         end
      end
      final_b = 8'($urandom_range(0, 255));
      in_data = final_b;
      tick();
      edge_n++;
      in_valid = 1'b0;
      in_data  = ~final_b;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_accept rdy got %b expected 0", in_ready);
      end
      while (edge_n < 2 * FRAME + 1) begin
         tick();
         edge_n++;
      end
      s[0] = tx;
      for (int j = 1; j < FRAME; j++) begin
         tick();
         s[j] = tx;
      end
      for (int n = 0; n < 8; n++) dec[n] = s[(n + 1) * N + N / 2];
      checks++;
      if (s[0] !== 1'b0 || s[FRAME-1] !== 1'b1 || dec !== final_b) begin
         errors++;
         $display("FAIL stall_byte start/stop %b%b byte got %h expected 01 %h",
                  s[0], s[FRAME-1], dec, final_b);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_end busy got %b expected 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      logic s[0:FRAME-1];
      logic [7:0] dec;
      ena      = 1'b1;
      in_data  = 8'hC3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int j = 0; j < 6 * N + 2; j++) tick();
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL mid_bit5 tx got %b expected 0", tx);
      end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_async tx/rdy/busy got %b%b%b expected 110", tx, in_ready, busy);
      end
      tick();
      rst = 1'b0;
      tick();
      in_data  = 8'h81;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int j = 0; j < FRAME; j++) begin
         tick();
         s[j] = tx;
      end
      for (int n = 0; n < 8; n++) dec[n] = s[(n + 1) * N + N / 2];
      checks++;
      if (s[0] !== 1'b0 || s[N-1] !== 1'b0 || s[FRAME-N] !== 1'b1 || dec !== 8'h81) begin
         errors++;
         $display("FAIL mid_next start/stop %b%b%b byte got %h expected 001 81",
                  s[0], s[N-1], s[FRAME-N], dec);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL mid_end busy/tx got %b%b expected 01", busy, tx);
      end
   endtask

   initial begin
      rst      = 1'b1;
      ena      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_ena_gating();
      test_stall();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete, errors so far %0d", errors);
      $fatal(1);
   end

endmodule
